// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use/RAW hazard scoreboard with EX operand forward selects
//
// Purpose: tracks register writers in flight from EX (stage 0) to WB (stage
//   NUM_STAGES-1), stalls decode when a source operand cannot yet be bypassed,
//   flushes IF/ID on a redirect, and produces registered forward selects for
//   the instruction entering EX.
// Optional feature macro: HAZARD_FWD_EN
//   defined     - operands are bypassed from the youngest producer; stall only
//                 when that producer's result is not ready yet.
//   not defined - no bypass; fwd_sel_o is tied 0 and decode stalls while any
//                 producer of a source sits ahead of WB.
// Ports:
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-low reset
//   id_valid_i     decode slot holds a real instruction
//   id_rs_i        packed source indices, src j at [j*REG_ADDR_W +: REG_ADDR_W]
//   id_rs_used_i   src j is actually read
//   id_rd_i        decode destination index
//   id_regwrite_i  decode instruction writes rd
//   id_is_load_i   decode instruction is a load
//   redirect_i     taken branch/jump resolved in EX this cycle
//   stall_o        hold PC and IF/ID, bubble into EX
//   flush_o        squash IF/ID
//   fwd_sel_o      per-source EX operand select: 0=regfile, k=stage k result
//   stage_valid_o  tracked-entry valid per stage
//   stall_cnt_o    saturating count of stall cycles
module hazard_scoreboard #(
  parameter int NUM_STAGES       = 3,
  parameter int REG_ADDR_W       = 5,
  parameter int NUM_SRC          = 2,
  parameter int LOAD_READY_STAGE = 1,
  localparam int SEL_W           = $clog2(NUM_STAGES)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          id_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]            id_rs_used_i,
  input  logic [REG_ADDR_W-1:0]         id_rd_i,
  input  logic                          id_regwrite_i,
  input  logic                          id_is_load_i,
  input  logic                          redirect_i,
  output logic                          stall_o,
  output logic                          flush_o,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic [NUM_STAGES-1:0]         stage_valid_o,
  output logic [15:0]                   stall_cnt_o
);

  // Destination index is only needed ahead of WB, since WB writers are
  // never matched (the regfile supplies same-cycle write data).
  logic [NUM_STAGES-1:0]                  valid_q;
  logic [NUM_STAGES-2:0][REG_ADDR_W-1:0]  rd_q;
  logic [15:0]                            cnt_q;

  logic [NUM_SRC-1:0]                     hit;
  logic                                   hazard;
  logic                                   insert;

`ifdef HAZARD_FWD_EN
  logic [NUM_STAGES-2:0]                  load_q;
  logic [NUM_SRC-1:0][SEL_W-1:0]          sel_q;
  logic [NUM_SRC-1:0][SEL_W-1:0]          hit_sel;
  logic [NUM_SRC-1:0]                     src_haz;
`else
  logic                                   unused_load;
  assign unused_load = id_is_load_i;
`endif

  // Producer search: scan oldest to youngest so the youngest match is the
  // last assignment and wins.
  always_comb begin
    hit = '0;
`ifdef HAZARD_FWD_EN
    hit_sel = '0;
    src_haz = '0;
`endif
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = NUM_STAGES - 2; k >= 0; k--) begin
        if (id_valid_i && id_rs_used_i[j] && valid_q[k] &&
            (rd_q[k] != '0) &&
            (rd_q[k] == id_rs_i[j*REG_ADDR_W +: REG_ADDR_W])) begin
          hit[j] = 1'b1;
`ifdef HAZARD_FWD_EN
          hit_sel[j] = SEL_W'(k + 1);
          // Result exists at the end of its ready stage; it can be bypassed
          // only once the producer has moved past that stage.
          src_haz[j] = ((k + 1) <= (load_q[k] ? LOAD_READY_STAGE : 0));
`endif
        end
      end
    end
`ifdef HAZARD_FWD_EN
    hazard = |src_haz;
`else
    hazard = |hit;
`endif
  end

  // Gate with reset so both strobes read 0 while reset is held.
  assign stall_o = hazard & ~redirect_i & reset_i;
  assign flush_o = redirect_i & reset_i;
  assign insert  = id_valid_i & ~stall_o & ~redirect_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef HAZARD_FWD_EN
      load_q  <= '0;
      sel_q   <= '0;
`endif
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 1; k < NUM_STAGES - 1; k++) begin
        rd_q[k] <= rd_q[k-1];
      end
      // A write to x0 is not a real producer, so it never occupies a slot.
      valid_q[0] <= insert & id_regwrite_i & (id_rd_i != '0);
      rd_q[0]    <= id_rd_i;
`ifdef HAZARD_FWD_EN
      for (int k = 1; k < NUM_STAGES - 1; k++) begin
        load_q[k] <= load_q[k-1];
      end
      load_q[0] <= id_is_load_i;
      // Select follows the instruction into EX; a bubble forwards nothing.
      sel_q     <= insert ? hit_sel : '0;
`endif
      if (stall_o && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

`ifdef HAZARD_FWD_EN
  assign fwd_sel_o = sel_q;
`else
  assign fwd_sel_o = '0;
`endif
  assign stage_valid_o = valid_q;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int NS   = 3;
  localparam int W    = 5;
  localparam int NSRC = 2;
  localparam int LRS  = 1;
  localparam int SW   = $clog2(NS);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 id_valid;
  logic [NSRC*W-1:0]    id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [W-1:0]         id_rd;
  logic                 id_regwrite;
  logic                 id_is_load;
  logic                 redirect;
  logic                 stall;
  logic                 flush;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic [NS-1:0]        stage_valid;
  logic [15:0]          stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int issue;
    int rd;
    bit ld;
  } rec_t;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_STAGES(NS), .REG_ADDR_W(W), .NUM_SRC(NSRC), .LOAD_READY_STAGE(LRS)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_rs_used), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_is_load_i(id_is_load), .redirect_i(redirect), .stall_o(stall),
    .flush_o(flush), .fwd_sel_o(fwd_sel), .stage_valid_o(stage_valid),
    .stall_cnt_o(stall_cnt)
  );

  task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit wr, input bit ld, input bit rdr);
    id_valid    = v;
    id_rs       = {W'(rs1), W'(rs0)};
    id_rs_used  = used;
    id_rd       = W'(rd);
    id_regwrite = wr;
    id_is_load  = ld;
    redirect    = rdr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    #3;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0b exp=0", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush got=%0b exp=0", flush); end
    n_cmp++; if (stage_valid !== 3'b000) begin n_bad++; $display("FAIL rst_stage_valid got=%0b exp=000", stage_valid); end
    n_cmp++; if (fwd_sel !== 4'h0) begin n_bad++; $display("FAIL rst_fwd_sel got=%0h exp=0", fwd_sel); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_stall_cnt got=%0h exp=0", stall_cnt); end
    reset_n = 1'b1;
  endtask

  // add x1 ; add x2,x1,x3
  task automatic test_alu_fwd();
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1, 3, 2'b11, 2, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef HAZARD_FWD_EN
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 4'b0001) begin n_bad++; $display("FAIL alu_fwd_sel got=%0b exp=0001", fwd_sel); end
    n_cmp++; if (stage_valid !== 3'b011) begin n_bad++; $display("FAIL alu_stage_valid got=%0b exp=011", stage_valid); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL alu_stall_cnt got=%0d exp=0", stall_cnt); end
`else
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_stall1 got=%0b exp=1", stall); end
    tick();
    n_cmp++; if (stage_valid !== 3'b010) begin n_bad++; $display("FAIL nofwd_sv1 got=%0b exp=010", stage_valid); end
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_stall2 got=%0b exp=1", stall); end
    tick();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nofwd_stall3 got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL nofwd_fwd_sel got=%0b exp=0000", fwd_sel); end
    n_cmp++; if (stage_valid !== 3'b001) begin n_bad++; $display("FAIL nofwd_sv3 got=%0b exp=001", stage_valid); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL nofwd_stall_cnt got=%0d exp=2", stall_cnt); end
`endif
    idle();
  endtask

  // lw x1 ; add x2,x1,x1
  task automatic test_load_use();
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1, 1, 2'b11, 2, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    tick();
    n_cmp++; if (stage_valid !== 3'b010) begin n_bad++; $display("FAIL lu_bubble got=%0b exp=010", stage_valid); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt1 got=%0d exp=1", stall_cnt); end
    #1;
`ifdef HAZARD_FWD_EN
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall2 got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 4'b1010) begin n_bad++; $display("FAIL lu_fwd_sel got=%0b exp=1010", fwd_sel); end
    n_cmp++; if (stage_valid !== 3'b101) begin n_bad++; $display("FAIL lu_sv2 got=%0b exp=101", stage_valid); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt2 got=%0d exp=1", stall_cnt); end
`else
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall2 got=%0b exp=1", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL lu_fwd_sel got=%0b exp=0000", fwd_sel); end
    n_cmp++; if (stage_valid !== 3'b100) begin n_bad++; $display("FAIL lu_sv2 got=%0b exp=100", stage_valid); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt); end
`endif
    idle();
  endtask

  // lw x5 ; use of x5 with a redirect in the same cycle
  task automatic test_redirect();
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5, 0, 2'b01, 6, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL rd_flush got=%0b exp=1", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rd_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (stage_valid !== 3'b010) begin n_bad++; $display("FAIL rd_sv got=%0b exp=010", stage_valid); end
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL rd_fwd_sel got=%0b exp=0000", fwd_sel); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rd_cnt got=%0d exp=0", stall_cnt); end
    idle();
    #1;
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rd_flush_off got=%0b exp=0", flush); end
  endtask

  // writer of x0 followed by reader of x0
  task automatic test_x0();
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 0, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++; if (stage_valid !== 3'b000) begin n_bad++; $display("FAIL x0_sv got=%0b exp=000", stage_valid); end
    drive(1'b1, 0, 0, 2'b11, 3, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall got=%0b exp=0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL x0_fwd_sel got=%0b exp=0000", fwd_sel); end
    n_cmp++; if (stage_valid !== 3'b001) begin n_bad++; $display("FAIL x0_sv2 got=%0b exp=001", stage_valid); end
    idle();
  endtask

  // reset asserted mid-cycle while a stall is pending and two entries valid
  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 0, 0, 2'b00, 1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 0, 0, 2'b00, 2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2, 0, 2'b01, 3, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mr_stall_pre got=%0b exp=1", stall); end
    n_cmp++; if (stage_valid !== 3'b011) begin n_bad++; $display("FAIL mr_sv_pre got=%0b exp=011", stage_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (stage_valid !== 3'b000) begin n_bad++; $display("FAIL mr_sv got=%0b exp=000", stage_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mr_stall got=%0b exp=0", stall); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mr_cnt got=%0d exp=0", stall_cnt); end
    tick();
    reset_n = 1'b1;
    idle();
  endtask

  // Random instruction stream against an issue-time model: each producer is
  // remembered with the cycle it entered EX, and its stage is its age.
  task automatic test_random();
    rec_t q[$];
    int cyc;
    int m_cnt;
    logic [NSRC*SW-1:0] m_sel;
    logic [NSRC*SW-1:0] sel_now;
    logic [NS-1:0] m_sv;
    int rs[NSRC];
    bit [NSRC-1:0] used;
    int rd, age, best;
    bit v, wr, ld, rdr, haz, m_stall, ins, best_ld;
    do_reset();
    cyc = 0;
    m_cnt = 0;
    m_sel = '0;
    for (int n = 0; n < 500; n++) begin
      v   = ($urandom_range(0, 9) < 8);
      rs[0] = $urandom_range(0, 3);
      rs[1] = $urandom_range(0, 3);
      used = NSRC'($urandom_range(0, 3));
      rd  = $urandom_range(0, 3);
      wr  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 2) == 0);
      rdr = ($urandom_range(0, 9) == 0);
      drive(v, rs[0], rs[1], used, rd, wr, ld, rdr);
      #1;
      haz = 1'b0;
      sel_now = '0;
      for (int j = 0; j < NSRC; j++) begin
        if (v && used[j] && rs[j] != 0) begin
          best = -1;
          best_ld = 1'b0;
          foreach (q[i]) begin
            age = cyc - q[i].issue;
            if (q[i].rd == rs[j] && age < NS - 1 && (best < 0 || age < best)) begin
              best = age;
              best_ld = q[i].ld;
            end
          end
          if (best >= 0) begin
            sel_now[j*SW +: SW] = SW'(best + 1);
`ifdef HAZARD_FWD_EN
            if (best + 1 <= (best_ld ? LRS : 0)) haz = 1'b1;
`else
            haz = 1'b1;
`endif
          end
        end
      end
      m_stall = haz & ~rdr;
      ins = v & ~m_stall & ~rdr;
      n_cmp++; if (stall !== m_stall) begin n_bad++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall, m_stall); end
      n_cmp++; if (flush !== rdr) begin n_bad++; $display("FAIL rnd_flush n=%0d got=%0b exp=%0b", n, flush, rdr); end
      tick();
      cyc++;
      if (m_stall && m_cnt < 65535) m_cnt++;
`ifdef HAZARD_FWD_EN
      m_sel = ins ? sel_now : '0;
`else
      m_sel = '0;
`endif
      if (ins && wr && rd != 0) q.push_back('{cyc, rd, ld});
      while (q.size() > 0 && (cyc - q[0].issue) >= NS) void'(q.pop_front());
      m_sv = '0;
      foreach (q[i]) m_sv[cyc - q[i].issue] = 1'b1;
      n_cmp++; if (stage_valid !== m_sv) begin n_bad++; $display("FAIL rnd_sv n=%0d got=%0b exp=%0b", n, stage_valid, m_sv); end
      n_cmp++; if (fwd_sel !== m_sel) begin n_bad++; $display("FAIL rnd_fwd_sel n=%0d got=%0b exp=%0b", n, fwd_sel, m_sel); end
      n_cmp++; if (stall_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_redirect();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
